// File: rtl/reservation_station.sv
// Reservation station: holds decoded ALU ops, wakes operands from the
// result broadcast and feeds one ready op at a time to the functional unit.
module reservation_station #(
  parameter int DEPTH  = 3,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [15:0]       issue_instr,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic              issue_qj_wait,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              issue_qk_wait,
  output logic              issue_err,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              fu_available,
  output logic              fu_issue,
  output logic [15:0]       fu_instruction,
  output logic [TAG_W-1:0]  fu_tag,
  output logic [DATA_W-1:0] fu_r2,
  output logic [DATA_W-1:0] fu_r1,
  output logic [2:0]        busy_count
);

  typedef enum logic [1:0] {
    IDLE,
    SENT,
    WAIT_BUSY,
    WAIT_FREE
  } state_t;

  typedef struct packed {
    logic [15:0]       instr;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qj;
    logic              wj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qk;
    logic              wk;
  } entry_t;

  state_t state_q, state_d;

  logic [DEPTH-1:0] valid_q, valid_d;
  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];

  logic [15:0]       fu_instr_q, fu_instr_d;
  logic [TAG_W-1:0]  fu_tag_q, fu_tag_d;
  logic [DATA_W-1:0] fu_r2_q, fu_r2_d;
  logic [DATA_W-1:0] fu_r1_q, fu_r1_d;
  logic              err_q, err_d;

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] rdy_oh;
  logic             any_rdy;
  logic             legal;
  logic             do_issue;
  logic             do_disp;
  entry_t           new_ent;
  entry_t           sel_ent;

  assign issue_ready = ~&valid_q;
  assign legal = issue_instr[3:0] inside {4'b0000, 4'b0001, 4'b0100, 4'b0101};
  assign do_issue = issue_valid & issue_ready & legal;
  assign err_d = issue_valid & issue_ready & ~legal;

  // Lowest-index free slot and lowest-index ready slot, one-hot.
  always_comb begin
    free_oh = '0;
    rdy_oh  = '0;
    sel_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = valid_q[i] & ~ent_q[i].wj & ~ent_q[i].wk;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
      if (rdy[i]) begin
        rdy_oh    = '0;
        rdy_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy_oh[i]) begin
        sel_ent = ent_q[i];
      end
    end
  end

  assign any_rdy = |rdy;
  assign do_disp = (state_q == IDLE) & fu_available & any_rdy;

  // Incoming op captures a same-edge broadcast for its pending sources.
  always_comb begin
    new_ent.instr = issue_instr;
    new_ent.tag   = issue_tag;
    new_ent.vj    = issue_vj;
    new_ent.qj    = issue_qj;
    new_ent.wj    = issue_qj_wait;
    new_ent.vk    = issue_vk;
    new_ent.qk    = issue_qk;
    new_ent.wk    = issue_qk_wait;
    if (cdb_valid && issue_qj_wait && issue_qj == cdb_tag) begin
      new_ent.vj = cdb_value;
      new_ent.wj = 1'b0;
    end
    if (cdb_valid && issue_qk_wait && issue_qk == cdb_tag) begin
      new_ent.vk = cdb_value;
      new_ent.wk = 1'b0;
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (cdb_valid && valid_q[i]) begin
        if (ent_q[i].wj && ent_q[i].qj == cdb_tag) begin
          ent_d[i].vj = cdb_value;
          ent_d[i].wj = 1'b0;
        end
        if (ent_q[i].wk && ent_q[i].qk == cdb_tag) begin
          ent_d[i].vk = cdb_value;
          ent_d[i].wk = 1'b0;
        end
      end
      if (do_disp && rdy_oh[i]) begin
        valid_d[i] = 1'b0;
      end
      if (do_issue && free_oh[i]) begin
        valid_d[i] = 1'b1;
        ent_d[i]   = new_ent;
      end
    end
  end

  always_comb begin
    fu_instr_d = fu_instr_q;
    fu_tag_d   = fu_tag_q;
    fu_r2_d    = fu_r2_q;
    fu_r1_d    = fu_r1_q;
    if (do_disp) begin
      fu_instr_d = sel_ent.instr;
      fu_tag_d   = sel_ent.tag;
      fu_r2_d    = sel_ent.vj;
      fu_r1_d    = sel_ent.vk;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (do_disp) state_d = SENT;
      SENT:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (!fu_available) state_d = WAIT_FREE;
      WAIT_FREE: if (fu_available) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    fu_issue   = (state_q == SENT);
    busy_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count = busy_count + {2'b00, valid_q[i]};
    end
  end

  assign fu_instruction = fu_instr_q;
  assign fu_tag         = fu_tag_q;
  assign fu_r2          = fu_r2_q;
  assign fu_r1          = fu_r1_q;
  assign issue_err      = err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      fu_instr_q <= 16'h000F;
      fu_tag_q   <= '0;
      fu_r2_q    <= '0;
      fu_r1_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      fu_instr_q <= fu_instr_d;
      fu_tag_q   <= fu_tag_d;
      fu_r2_q    <= fu_r2_d;
      fu_r1_q    <= fu_r1_d;
      err_q      <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station against a latency-2
// behavioural functional unit.
module tb_reservation_station;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [15:0] issue_instr = '0;
  logic [2:0]  issue_tag = '0;
  logic [15:0] issue_vj = '0;
  logic [2:0]  issue_qj = '0;
  logic        issue_qj_wait = 1'b0;
  logic [15:0] issue_vk = '0;
  logic [2:0]  issue_qk = '0;
  logic        issue_qk_wait = 1'b0;
  logic        issue_err;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [15:0] cdb_value = '0;
  logic        fu_available;
  logic        fu_issue;
  logic [15:0] fu_instruction;
  logic [2:0]  fu_tag;
  logic [15:0] fu_r2;
  logic [15:0] fu_r1;
  logic [2:0]  busy_count;

  logic        hold = 1'b0;
  logic        m_avail = 1'b1;
  int          m_cnt = 0;
  int          npulse = 0;
  int          viol = 0;
  logic [2:0]  plog [16];

  int n_chk = 0;
  int n_err = 0;

  reservation_station #(
    .DEPTH(3),
    .TAG_W(3),
    .DATA_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_instr(issue_instr),
    .issue_tag(issue_tag),
    .issue_vj(issue_vj),
    .issue_qj(issue_qj),
    .issue_qj_wait(issue_qj_wait),
    .issue_vk(issue_vk),
    .issue_qk(issue_qk),
    .issue_qk_wait(issue_qk_wait),
    .issue_err(issue_err),
    .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag),
    .cdb_value(cdb_value),
    .fu_available(fu_available),
    .fu_issue(fu_issue),
    .fu_instruction(fu_instruction),
    .fu_tag(fu_tag),
    .fu_r2(fu_r2),
    .fu_r1(fu_r1),
    .busy_count(busy_count)
  );

  always #5 clock = ~clock;

  assign fu_available = m_avail & ~hold;

  // Unit drops availability on the accepting edge, busy for 2 cycles.
  always @(posedge clock) begin
    if (m_avail && fu_issue) begin
      m_avail <= 1'b0;
      m_cnt   <= 2;
    end else if (!m_avail) begin
      if (m_cnt <= 1) m_avail <= 1'b1;
      else m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clock) begin
    if (fu_issue) begin
      if (npulse < 16) plog[npulse] <= fu_tag;
      npulse <= npulse + 1;
      if (!fu_available) viol <= viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic put(input logic [15:0] ins, input logic [2:0] tg,
                     input logic [15:0] vj, input logic [2:0] qj,
                     input logic wj, input logic [15:0] vk,
                     input logic [2:0] qk, input logic wk);
    issue_valid   = 1'b1;
    issue_instr   = ins;
    issue_tag     = tg;
    issue_vj      = vj;
    issue_qj      = qj;
    issue_qj_wait = wj;
    issue_vk      = vk;
    issue_qk      = qk;
    issue_qk_wait = wk;
    step();
    issue_valid   = 1'b0;
  endtask

  task automatic wait_issue(input int lim, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!fu_issue && n < lim);
    chk("issue_seen", 32'(fu_issue), 32'd1);
  endtask

  int n;
  int base;

  initial begin
    idle(2);
    chk("rst_issue", 32'(fu_issue), 32'd0);
    chk("rst_instr", 32'(fu_instruction), 32'h000F);
    chk("rst_tag", 32'(fu_tag), 32'd0);
    chk("rst_r1", 32'(fu_r1), 32'd0);
    chk("rst_r2", 32'(fu_r2), 32'd0);
    chk("rst_busy", 32'(busy_count), 32'd0);
    chk("rst_err", 32'(issue_err), 32'd0);
    chk("rst_ready", 32'(issue_ready), 32'd1);
    reset = 1'b0;
    idle(2);

    // Ready ADD dispatches on the next edge.
    put(16'h0000, 3'd1, 16'd5, 3'd0, 1'b0, 16'd3, 3'd0, 1'b0);
    chk("t1_busy1", 32'(busy_count), 32'd1);
    wait_issue(6, n);
    chk("t1_lat", 32'(n), 32'd1);
    chk("t1_r2", 32'(fu_r2), 32'd5);
    chk("t1_r1", 32'(fu_r1), 32'd3);
    chk("t1_tag", 32'(fu_tag), 32'd1);
    chk("t1_instr", 32'(fu_instruction), 32'h0000);
    chk("t1_busy0", 32'(busy_count), 32'd0);
    step();
    chk("t1_pulse1", 32'(fu_issue), 32'd0);
    idle(6);
    chk("t1_hold_r2", 32'(fu_r2), 32'd5);
    chk("t1_hold_tag", 32'(fu_tag), 32'd1);

    // SUB waits on tag 4 until the broadcast.
    put(16'h0001, 3'd2, 16'd0, 3'd4, 1'b1, 16'd2, 3'd0, 1'b0);
    idle(2);
    chk("t2_wait_iss", 32'(fu_issue), 32'd0);
    chk("t2_wait_busy", 32'(busy_count), 32'd1);
    cdb_valid = 1'b1;
    cdb_tag   = 3'd4;
    cdb_value = 16'd10;
    step();
    cdb_valid = 1'b0;
    chk("t2_not_early", 32'(fu_issue), 32'd0);
    wait_issue(6, n);
    chk("t2_lat", 32'(n), 32'd1);
    chk("t2_r2", 32'(fu_r2), 32'd10);
    chk("t2_r1", 32'(fu_r1), 32'd2);
    chk("t2_tag", 32'(fu_tag), 32'd2);
    chk("t2_instr", 32'(fu_instruction), 32'h0001);
    idle(6);

    // Same-edge bypass of the broadcast into the issued entry.
    cdb_valid = 1'b1;
    cdb_tag   = 3'd6;
    cdb_value = 16'd7;
    put(16'h0000, 3'd5, 16'd0, 3'd6, 1'b1, 16'd9, 3'd0, 1'b0);
    cdb_valid = 1'b0;
    wait_issue(6, n);
    chk("t3_lat", 32'(n), 32'd1);
    chk("t3_r2", 32'(fu_r2), 32'd7);
    chk("t3_r1", 32'(fu_r1), 32'd9);
    chk("t3_tag", 32'(fu_tag), 32'd5);
    idle(6);

    // Fill with unit unavailable, then drain in order.
    hold = 1'b1;
    put(16'h0004, 3'd1, 16'd2, 3'd0, 1'b0, 16'd3, 3'd0, 1'b0);
    put(16'h0004, 3'd2, 16'd4, 3'd0, 1'b0, 16'd5, 3'd0, 1'b0);
    put(16'h0004, 3'd3, 16'd6, 3'd0, 1'b0, 16'd7, 3'd0, 1'b0);
    chk("t4_full_busy", 32'(busy_count), 32'd3);
    chk("t4_full_rdy", 32'(issue_ready), 32'd0);
    put(16'h0004, 3'd7, 16'd1, 3'd0, 1'b0, 16'd1, 3'd0, 1'b0);
    chk("t4_ovf_busy", 32'(busy_count), 32'd3);
    chk("t4_ovf_err", 32'(issue_err), 32'd0);
    base = npulse;
    hold = 1'b0;
    idle(40);
    chk("t4_npulse", 32'(npulse - base), 32'd3);
    chk("t4_tag_a", 32'(plog[base]), 32'd1);
    chk("t4_tag_b", 32'(plog[base + 1]), 32'd2);
    chk("t4_tag_c", 32'(plog[base + 2]), 32'd3);
    chk("t4_busy0", 32'(busy_count), 32'd0);
    chk("t4_last_r1", 32'(fu_r1), 32'd7);

    // Illegal opcode.
    base = npulse;
    put(16'h0003, 3'd3, 16'd1, 3'd0, 1'b0, 16'd1, 3'd0, 1'b0);
    chk("t5_err", 32'(issue_err), 32'd1);
    chk("t5_busy", 32'(busy_count), 32'd0);
    step();
    chk("t5_err_clr", 32'(issue_err), 32'd0);
    idle(6);
    chk("t5_no_disp", 32'(npulse - base), 32'd0);

    // Reset while waiting for the unit to go busy.
    hold = 1'b1;
    put(16'h0004, 3'd4, 16'd1, 3'd0, 1'b0, 16'd1, 3'd0, 1'b0);
    put(16'h0004, 3'd5, 16'd2, 3'd0, 1'b0, 16'd2, 3'd0, 1'b0);
    put(16'h0004, 3'd6, 16'd3, 3'd0, 1'b0, 16'd3, 3'd0, 1'b0);
    hold = 1'b0;
    wait_issue(6, n);
    step();
    chk("t6_pre_busy", 32'(busy_count), 32'd2);
    chk("t6_pre_instr", 32'(fu_instruction), 32'h0004);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_issue", 32'(fu_issue), 32'd0);
    chk("t6_rst_busy", 32'(busy_count), 32'd0);
    chk("t6_rst_instr", 32'(fu_instruction), 32'h000F);
    chk("t6_rst_ready", 32'(issue_ready), 32'd1);
    step();
    reset = 1'b0;
    base = npulse;
    idle(20);
    chk("t6_no_disp", 32'(npulse - base), 32'd0);
    chk("protocol", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
